mem_bus_arbiter: RTL and testbench
==================================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  ADDR_W  32  address width
  DATA_W  32  data width
  TMO_CYC  64  cycles allowed per memory transaction before timeout, legal range 2..255
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  in  1  single clock, rising edge
  reset  in  1  asynchronous, active-high reset
  if_req  in  1  instruction-fetch read request, held until if_ack
  if_addr  in  ADDR_W  fetch address
  if_rdata  out  DATA_W  fetch read data, valid with if_ack
  if_ack  out  1  one-cycle fetch completion pulse
  d_req  in  1  data request, held until d_ack
  d_we  in  1  data write enable
  d_addr  in  ADDR_W  data address
  d_wdata  in  DATA_W  data write value
  d_rdata  out  DATA_W  data read value, valid with d_ack
  d_ack  out  1  one-cycle data completion pulse
  address_bus  out  ADDR_W  memory address
  data_bus_out  out  DATA_W  memory write data
  data_bus_in  in  DATA_W  memory read data, valid with mem_ack
  mem_req  out  1  memory request, held until mem_ack or timeout
  mem_we  out  1  memory write strobe
  mem_ack  in  1  memory completion
  tmo_err  out  1  sticky timeout flag
REQ-003 Clock and reset SHALL be exactly as decided: one clock, clk; reset is asynchronous and active-high, reset.

Function
REQ-004 FSM SHALL have states IDLE, BUSY, TURN; all outputs SHALL be registered.
REQ-005 IDLE: a pending request SHALL trigger a grant; address_bus, data_bus_out and mem_we SHALL be registered from the winner; mem_req SHALL go high on the next cycle; the FSM SHALL enter BUSY.
REQ-006 Latency: a request seen in IDLE at cycle N SHALL give mem_req=1 at N+1; mem_ack at cycle M SHALL give the requester ack=1 at M+1.
REQ-007 BUSY: on mem_ack, data_bus_in SHALL be latched into the granted rdata (reads only; rdata SHALL hold its old value on writes), the granted ack SHALL pulse for exactly one cycle, mem_req and mem_we SHALL drop, and the FSM SHALL enter TURN.
REQ-008 TURN SHALL last exactly one cycle, then IDLE; a new grant SHALL never occur in the cycle an ack is pulsed.
REQ-009 Fetch requests SHALL always drive mem_we=0 and data_bus_out SHALL hold its previous value.
REQ-010 In BUSY, a cycle counter SHALL count from 0; if it reaches TMO_CYC-1 without mem_ack, the transaction SHALL abort: ack SHALL pulse with rdata set to all ones, tmo_err SHALL set, and the FSM SHALL enter TURN.
REQ-011 A req deasserted mid-transaction SHALL be ignored; the transaction SHALL complete and ack SHALL still pulse.
REQ-012 mem_ack outside BUSY SHALL be ignored.
REQ-013 tmo_err SHALL clear only on reset.

Reset
REQ-014 When reset is asserted, the FSM SHALL go to IDLE immediately, regardless of clk, aborting any transaction without an ack.
REQ-015 Reset values SHALL be: mem_req, mem_we, if_ack, d_ack and tmo_err = 0; address_bus, data_bus_out, if_rdata and d_rdata = 0; the counter = 0; the round-robin pointer favours fetch.

Configuration
REQ-016 With ARB_ROUND_ROBIN_EN defined: on simultaneous requests, the grant SHALL go to the requester not served last, and the pointer SHALL update on every completion or timeout.
REQ-017 Without ARB_ROUND_ROBIN_EN: on simultaneous requests, data SHALL always win over fetch.

Structure
REQ-018 A shared package SHALL hold the state enum (IDLE/BUSY/TURN), the requester-id enum (REQ_IF, REQ_D) and the all-ones timeout read constant.
REQ-019 The arbitration decision SHALL be one sub-module, arb_pick (inputs: both requests and the pointer; output: the winner id); the FSM, counter and datapath SHALL stay in mem_bus_arbiter.

Verification
REQ-020 Single fetch: if_req=1, if_addr=0x100; memory acks after 3 cycles with 0xDEADBEEF -> address_bus=0x100, mem_we=0, if_ack pulses once, if_rdata=0xDEADBEEF.
REQ-021 Data write: d_we=1, d_addr=0x200, d_wdata=0x12345678 -> mem_we=1, data_bus_out=0x12345678, d_ack pulses once, d_rdata unchanged.
REQ-022 Simultaneous requests, held for 4 transactions -> grant order is D,D,D,D without the macro and IF,D,IF,D with it (pointer starts favouring fetch), with one TURN cycle between transactions.
REQ-023 Timeout: with TMO_CYC=8, a d_req read is never acked -> d_ack pulses 8 cycles after mem_req rises, d_rdata=0xFFFFFFFF, tmo_err=1 until reset.
REQ-024 Reset mid-BUSY: reset is asserted between clock edges -> mem_req drops immediately, no ack is pulsed, and a fresh request then completes normally.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the two-master memory bus arbiter.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    TURN = 2'd2
  } state_t;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_D  = 1'b1
  } req_id_t;

  // Width of the transaction timeout counter (TMO_CYC is at most 255)
  localparam int unsigned CNT_W = 8;

  // Read data returned to a requester whose transaction timed out
  localparam int unsigned TMO_RDATA_MAX_W = 256;
  localparam logic [TMO_RDATA_MAX_W-1:0] TMO_RDATA = '1;

  // The requester that was not just served
  function automatic req_id_t other_req(input req_id_t id);
    return (id == REQ_D) ? REQ_IF : REQ_D;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_arb_pick.sv
// Arbitration decision between fetch and data requesters.
// Optional feature macro: ARB_ROUND_ROBIN_EN (alternate on contention);
// default build gives data priority over fetch.
module arb_pick
  import mem_bus_arbiter_pkg::*;
(
  input  logic    i_if_req,
  input  logic    i_d_req,
  input  req_id_t i_ptr,
  output req_id_t o_winner_c
);

  // Pick the winner; with no request the pointer value is a don't-care
  always_comb begin
    o_winner_c = i_ptr;
    if (i_if_req && i_d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      o_winner_c = i_ptr;
`else
      o_winner_c = REQ_D;
`endif
    end else if (i_d_req) begin
      o_winner_c = REQ_D;
    end else if (i_if_req) begin
      o_winner_c = REQ_IF;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one memory bus,
// with a per-transaction timeout and a sticky timeout flag.
// Optional feature macro: ARB_ROUND_ROBIN_EN (see arb_pick).
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TMO_CYC = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic [ADDR_W-1:0] address_bus,
  output logic [DATA_W-1:0] data_bus_out,
  input  logic [DATA_W-1:0] data_bus_in,
  output logic              mem_req,
  output logic              mem_we,
  input  logic              mem_ack,
  output logic              tmo_err
);

  state_t            r_state;
  req_id_t           r_gnt;
  req_id_t           r_ptr;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_mem_req;
  logic              r_mem_we;
  logic              r_if_ack;
  logic              r_d_ack;
  logic              r_tmo_err;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_d_rdata;

  req_id_t           w_winner;
  logic              w_any_req;
  logic              w_tmo;
  logic              w_done;
  logic [DATA_W-1:0] w_tmo_rdata;

  assign w_any_req   = if_req | d_req;
  assign w_tmo       = (r_cnt == CNT_W'(TMO_CYC - 1));
  assign w_done      = mem_ack | w_tmo;
  assign w_tmo_rdata = DATA_W'(TMO_RDATA);

  arb_pick u_arb_pick (
    .i_if_req   (if_req),
    .i_d_req    (d_req),
    .i_ptr      (r_ptr),
    .o_winner_c (w_winner)
  );

  // Grant / wait for memory / one-cycle turnaround, with registered bus and acks
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_gnt      <= REQ_IF;
      r_ptr      <= REQ_IF;
      r_cnt      <= '0;
      r_mem_req  <= 1'b0;
      r_mem_we   <= 1'b0;
      r_if_ack   <= 1'b0;
      r_d_ack    <= 1'b0;
      r_tmo_err  <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else begin
      r_if_ack <= 1'b0;
      r_d_ack  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_gnt     <= w_winner;
            r_mem_req <= 1'b1;
            r_cnt     <= '0;
            r_state   <= BUSY;
            if (w_winner == REQ_D) begin
              r_addr   <= d_addr;
              r_mem_we <= d_we;
              r_wdata  <= d_wdata;
            end else begin
              r_addr   <= if_addr;
              r_mem_we <= 1'b0;
            end
          end
        end
        BUSY: begin
          if (w_done) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_ptr     <= other_req(r_gnt);
            r_state   <= TURN;
            if (!mem_ack) begin
              r_tmo_err <= 1'b1;
            end
            if (r_gnt == REQ_D) begin
              r_d_ack <= 1'b1;
              if (!mem_ack) begin
                r_d_rdata <= w_tmo_rdata;
              end else if (!r_mem_we) begin
                r_d_rdata <= data_bus_in;
              end
            end else begin
              r_if_ack   <= 1'b1;
              r_if_rdata <= mem_ack ? data_bus_in : w_tmo_rdata;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        TURN: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign if_rdata     = r_if_rdata;
  assign if_ack       = r_if_ack;
  assign d_rdata      = r_d_rdata;
  assign d_ack        = r_d_ack;
  assign address_bus  = r_addr;
  assign data_bus_out = r_wdata;
  assign mem_req      = r_mem_req;
  assign mem_we       = r_mem_we;
  assign tmo_err      = r_tmo_err;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: random requesters and memory,
// expected acks queued by the memory model, checked by a monitor.
module tb_mem_bus_arbiter;

  localparam int unsigned TMO = 8;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic [31:0] address_bus;
  logic [31:0] data_bus_out;
  logic [31:0] data_bus_in;
  logic        mem_req;
  logic        mem_we;
  logic        mem_ack;
  logic        tmo_err;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TMO_CYC(TMO)) dut (
    .clk          (clk),
    .reset        (reset),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .if_rdata     (if_rdata),
    .if_ack       (if_ack),
    .d_req        (d_req),
    .d_we         (d_we),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .d_rdata      (d_rdata),
    .d_ack        (d_ack),
    .address_bus  (address_bus),
    .data_bus_out (data_bus_out),
    .data_bus_in  (data_bus_in),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_ack      (mem_ack),
    .tmo_err      (tmo_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit          is_d;
    logic [31:0] rdata;
    int          due;
    bit          tmo;
  } exp_t;

  exp_t        sb_q[$];
  bit          gnt_log[$];
  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  // reference model state
  bit          in_txn = 1'b0;
  bit          cur_d = 1'b0;
  bit          cur_we = 1'b0;
  bit          last_d = 1'b1;
  bit          exp_tmo = 1'b0;
  int          grant_ok = 0;
  logic [31:0] exp_dbo = 32'd0;
  logic [31:0] exp_if_rd = 32'd0;
  logic [31:0] exp_d_rd = 32'd0;
  // memory model controls
  bit          no_ack_mode = 1'b0;
  bit          tmo_rand_en = 1'b0;
  bit          spurious_en = 1'b0;
  int          force_lat = -1;
  bit          force_data_en = 1'b0;
  logic [31:0] force_data = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor: grant rules, bus contents and ack scoreboard, sampled after each edge
  initial begin : monitor
    exp_t e;
    bit   any;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (reset) begin
        sb_q.delete();
        in_txn    = 1'b0;
        last_d    = 1'b1;
        exp_tmo   = 1'b0;
        exp_dbo   = 32'd0;
        exp_if_rd = 32'd0;
        exp_d_rd  = 32'd0;
        grant_ok  = cyc + 1;
      end else if (if_ack || d_ack) begin
        if (sb_q.size() == 0) begin
          fail("unexpected_ack");
        end else begin
          e = sb_q.pop_front();
          if (e.tmo) exp_tmo = 1'b1;
          chk("ack_select", {30'd0, if_ack, d_ack}, e.is_d ? 32'd1 : 32'd2);
          chk("ack_cycle", 32'(cyc), 32'(e.due));
          chk("ack_rdata", e.is_d ? d_rdata : if_rdata, e.rdata);
          chk("other_rdata", e.is_d ? if_rdata : d_rdata, e.is_d ? exp_if_rd : exp_d_rd);
          chk("tmo_err", 32'(tmo_err), 32'(exp_tmo));
          chk("mem_req_drop", {30'd0, mem_req, mem_we}, 32'd0);
          last_d = e.is_d;
        end
        in_txn   = 1'b0;
        grant_ok = cyc + 2;
      end else if (sb_q.size() > 0 && sb_q[0].due < cyc) begin
        fail("ack_missing");
        e        = sb_q.pop_front();
        in_txn   = 1'b0;
        grant_ok = cyc + 2;
      end else if (in_txn) begin
        chk("mem_req_hold", 32'(mem_req), 32'd1);
      end else if (cyc < grant_ok) begin
        chk("no_grant_in_turn", 32'(mem_req), 32'd0);
      end else begin
        any = if_req | d_req;
        chk("grant_latency", 32'(mem_req), 32'(any));
        if (any && mem_req) begin
          if (if_req && d_req) cur_d = RR ? !last_d : 1'b1;
          else                 cur_d = d_req;
          cur_we = cur_d & d_we;
          if (cur_d) exp_dbo = d_wdata;
          chk("address_bus", address_bus, cur_d ? d_addr : if_addr);
          chk("mem_we", 32'(mem_we), 32'(cur_we));
          chk("data_bus_out", data_bus_out, exp_dbo);
          gnt_log.push_back(cur_d);
          in_txn = 1'b1;
        end
      end
    end
  end

  // Memory model: answers each transaction and queues the requester response
  initial begin : mem_model
    exp_t        e;
    int          lat;
    bit          active;
    logic [31:0] v;
    mem_ack     = 1'b0;
    data_bus_in = 32'd0;
    active      = 1'b0;
    lat         = -1;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (reset || !mem_req) begin
        active = 1'b0;
        if (!reset && spurious_en && $urandom_range(0, 5) == 0) begin
          data_bus_in = $urandom;
          mem_ack     = 1'b1;
        end
      end else begin
        if (!active) begin
          active = 1'b1;
          if (no_ack_mode || (tmo_rand_en && $urandom_range(0, 7) == 0)) begin
            lat     = -1;
            e.is_d  = cur_d;
            e.rdata = 32'hFFFF_FFFF;
            e.due   = cyc + int'(TMO);
            e.tmo   = 1'b1;
            if (cur_d) exp_d_rd = e.rdata;
            else       exp_if_rd = e.rdata;
            sb_q.push_back(e);
          end else begin
            lat = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 4));
          end
        end
        if (lat == 0) begin
          v           = force_data_en ? force_data : $urandom;
          data_bus_in = v;
          mem_ack     = 1'b1;
          e.is_d      = cur_d;
          e.tmo       = 1'b0;
          e.due       = cyc + 1;
          e.rdata     = (cur_d && cur_we) ? exp_d_rd : v;
          if (cur_d) exp_d_rd = e.rdata;
          else       exp_if_rd = e.rdata;
          sb_q.push_back(e);
          lat = -1;
        end else if (lat > 0) begin
          lat--;
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  task automatic req_fetch(input logic [31:0] addr, input int gap);
    int t;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    if_addr = addr;
    if_req  = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!if_ack && t < 100);
    chk("if_ack_wait", 32'(if_ack), 32'd1);
    if_req = 1'b0;
  endtask

  task automatic req_data(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input bit drop_early, input int gap);
    int t;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    d_we    = we;
    d_addr  = addr;
    d_wdata = wdata;
    d_req   = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
      if (drop_early && mem_req && !d_ack) d_req = 1'b0;
    end while (!d_ack && t < 100);
    chk("d_ack_wait", 32'(d_ack), 32'd1);
    d_req = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset  = 1'b1;
    if_req = 1'b0;
    d_req  = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin : main
    bit exp_order[4];
    int n_if;
    int n_d;
    int t;
    reset   = 1'b1;
    if_req  = 1'b0;
    if_addr = 32'd0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = 32'd0;
    d_wdata = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_if_ack", 32'(if_ack), 32'd0);
    chk("rst_d_ack", 32'(d_ack), 32'd0);
    chk("rst_tmo_err", 32'(tmo_err), 32'd0);
    chk("rst_address_bus", address_bus, 32'd0);
    chk("rst_data_bus_out", data_bus_out, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    reset = 1'b0;

    // single fetch answered with a fixed word
    force_lat     = 3;
    force_data_en = 1'b1;
    force_data    = 32'hDEAD_BEEF;
    req_fetch(32'h0000_0100, 0);
    chk("fetch_rdata", if_rdata, 32'hDEAD_BEEF);
    force_data_en = 1'b0;

    // data write leaves d_rdata alone
    req_data(1'b1, 32'h0000_0200, 32'h1234_5678, 1'b0, 0);
    chk("write_d_rdata", d_rdata, 32'd0);
    chk("write_data_bus_out", data_bus_out, 32'h1234_5678);
    force_lat = -1;

    // contention: both held from the same cycle
    do_reset();
    gnt_log.delete();
    if (RR) begin
      n_if = 2; n_d = 2;
      exp_order[0] = 1'b0; exp_order[1] = 1'b1; exp_order[2] = 1'b0; exp_order[3] = 1'b1;
    end else begin
      n_if = 1; n_d = 4;
      exp_order[0] = 1'b1; exp_order[1] = 1'b1; exp_order[2] = 1'b1; exp_order[3] = 1'b1;
    end
    fork
      begin
        for (int i = 0; i < n_if; i++) req_fetch(32'h1000 + 32'(i * 4), 0);
      end
      begin
        for (int i = 0; i < n_d; i++) req_data(1'b0, 32'h2000 + 32'(i * 4), 32'd0, 1'b0, 0);
      end
    join
    chk("grant_count", 32'(gnt_log.size() >= 4), 32'd1);
    if (gnt_log.size() >= 4) begin
      for (int i = 0; i < 4; i++) chk("grant_order", 32'(gnt_log[i]), 32'(exp_order[i]));
    end

    // request withdrawn after grant still completes
    req_data(1'b0, 32'h0000_0300, 32'd0, 1'b1, 1);

    // read never acknowledged by memory
    no_ack_mode = 1'b1;
    req_data(1'b0, 32'h0000_0400, 32'd0, 1'b0, 1);
    no_ack_mode = 1'b0;
    chk("tmo_d_rdata", d_rdata, 32'hFFFF_FFFF);
    chk("tmo_err_set", 32'(tmo_err), 32'd1);

    // random traffic with spurious memory acks and occasional timeouts
    spurious_en = 1'b1;
    tmo_rand_en = 1'b1;
    fork
      begin
        for (int i = 0; i < 40; i++) req_fetch($urandom, int'($urandom_range(0, 3)));
      end
      begin
        for (int i = 0; i < 40; i++)
          req_data(1'($urandom_range(0, 1)), $urandom, $urandom, 1'b0, int'($urandom_range(0, 3)));
      end
    join
    spurious_en = 1'b0;
    tmo_rand_en = 1'b0;
    chk("tmo_err_sticky", 32'(tmo_err), 32'd1);

    // asynchronous reset while a transaction is outstanding
    no_ack_mode = 1'b1;
    @(negedge clk);
    d_we   = 1'b0;
    d_addr = 32'h0000_0500;
    d_req  = 1'b1;
    t = 0;
    while (!mem_req && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("busy_before_reset", 32'(mem_req), 32'd1);
    repeat (2) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_mem_req", 32'(mem_req), 32'd0);
    chk("async_reset_acks", {30'd0, if_ack, d_ack}, 32'd0);
    d_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    no_ack_mode = 1'b0;
    chk("reset_clears_tmo", 32'(tmo_err), 32'd0);
    req_data(1'b0, 32'h0000_0600, 32'd0, 1'b0, 1);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
